// File: rtl/tape_ram_pkg.sv
// Shared types for the tape RAM arbiter: data width, request bundle, grant code.
// Requests carry addresses zero-extended to ADDR_W_MAX so one struct serves any addrSize <= 16.
// Hazard helper: read that targets the address written in the previous cycle.
package tape_ram_pkg;

  localparam int DATA_W     = 8;
  localparam int ADDR_W_MAX = 16;

  typedef struct packed {
    logic                  valid;
    logic                  write;
    logic [ADDR_W_MAX-1:0] addr;
    logic [DATA_W-1:0]     wdata;
  } req_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_C    = 2'd1,
    GNT_H    = 2'd2
  } gnt_t;

  // A read in the cycle after a write to the same address would see stale RAM data.
  function automatic logic is_hazard(input req_t r, input logic lw_vld,
                                     input logic [ADDR_W_MAX-1:0] lw_addr);
    return r.valid & ~r.write & lw_vld & (r.addr == lw_addr);
  endfunction

endpackage

// File: rtl/tape_ram_arbiter_if.sv
// Bundle of the core (C) and host (H) request/response signals plus the RAM control signals.
// slave = arbiter side; master = requesters and RAM side.
// Requesters hold valid/addr/data stable until ready is seen.
interface tape_ram_arbiter_if #(parameter int addrSize = 9);
  import tape_ram_pkg::*;

  logic                c_valid;
  logic                c_write;
  logic [addrSize-1:0] c_addr;
  logic [DATA_W-1:0]   c_wdata;
  logic                c_ready;
  logic                c_rvalid;
  logic [DATA_W-1:0]   c_rdata;

  logic                h_valid;
  logic                h_write;
  logic [addrSize-1:0] h_addr;
  logic [DATA_W-1:0]   h_wdata;
  logic                h_ready;
  logic                h_rvalid;
  logic [DATA_W-1:0]   h_rdata;

  logic [addrSize-1:0] ram_addr_in;
  logic [DATA_W-1:0]   ram_dataIn;
  logic                ram_write_rq;
  logic [addrSize-1:0] ram_addr_out;
  logic [DATA_W-1:0]   ram_dataOut;
  logic                ram_reset_n;

  modport slave (
    input  c_valid, c_write, c_addr, c_wdata,
    output c_ready, c_rvalid, c_rdata,
    input  h_valid, h_write, h_addr, h_wdata,
    output h_ready, h_rvalid, h_rdata,
    output ram_addr_in, ram_dataIn, ram_write_rq, ram_addr_out, ram_reset_n,
    input  ram_dataOut
  );

  modport master (
    output c_valid, c_write, c_addr, c_wdata,
    input  c_ready, c_rvalid, c_rdata,
    output h_valid, h_write, h_addr, h_wdata,
    input  h_ready, h_rvalid, h_rdata,
    input  ram_addr_in, ram_dataIn, ram_write_rq, ram_addr_out, ram_reset_n,
    output ram_dataOut
  );

endinterface

// File: rtl/tape_ram_rd_port.sv
// Per-requester read return register: captures RAM (or forwarded) data on read accept.
// Latency 1: rvalid pulses the cycle after accept; rdata holds until the next read.
// No backpressure; reset masks outputs immediately so an in-flight rvalid is dropped.
module tape_ram_rd_port
  import tape_ram_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_acc,
  input  logic              fwd,
  input  logic [DATA_W-1:0] fwd_data,
  input  logic [DATA_W-1:0] ram_data,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);

  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  // Capture read data on accept; forwarded data replaces the stale RAM value.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) rdata_q <= fwd ? fwd_data : ram_data;
    end
  end

  // Reset asserted the cycle after an accept must still suppress the response.
  always_comb begin
    rvalid = rvalid_q & ~reset;
    rdata  = reset ? '0 : rdata_q;
  end

endmodule

// File: rtl/tape_ram_arbiter.sv
// Arbitrates core (C) and host (H) access to the tape RAM; C priority, H wins after MAX_WAIT stalls.
// Writes/read addresses issued in the accept cycle; read data returned one cycle later.
// Read-after-write hazard: forwarded if RAM_ARB_FWD_EN is defined, otherwise the hazard read stalls 1 cycle.
module tape_ram_arbiter
  import tape_ram_pkg::*;
#(
  parameter int addrSize = 9,
  parameter int MAX_WAIT = 8
) (
  input logic               clk,
  input logic               reset,
  tape_ram_arbiter_if.slave bus
);

  req_t                  c_req, h_req, win;
  gnt_t                  gnt;
  logic [7:0]            wait_cnt;
  logic                  last_wr_vld;
  logic [ADDR_W_MAX-1:0] last_wr_addr;
  logic [DATA_W-1:0]     last_wr_data;
  logic                  c_haz, h_haz, c_block, h_block, c_fwd, h_fwd;
  logic                  c_elig, h_elig, h_pri, wr_acc, c_rd_acc, h_rd_acc;

  // Pack both requesters into the common request format.
  always_comb begin
    c_req       = '0;
    c_req.valid = bus.c_valid;
    c_req.write = bus.c_write;
    c_req.addr  = ADDR_W_MAX'(bus.c_addr);
    c_req.wdata = bus.c_wdata;
    h_req       = '0;
    h_req.valid = bus.h_valid;
    h_req.write = bus.h_write;
    h_req.addr  = ADDR_W_MAX'(bus.h_addr);
    h_req.wdata = bus.h_wdata;
  end

  assign c_haz = is_hazard(c_req, last_wr_vld, last_wr_addr);
  assign h_haz = is_hazard(h_req, last_wr_vld, last_wr_addr);

`ifdef RAM_ARB_FWD_EN
  assign c_block = 1'b0;
  assign h_block = 1'b0;
  assign c_fwd   = c_haz;
  assign h_fwd   = h_haz;
`else
  assign c_block = c_haz;
  assign h_block = h_haz;
  assign c_fwd   = 1'b0;
  assign h_fwd   = 1'b0;
`endif

  assign c_elig = c_req.valid & ~c_block & ~reset;
  assign h_elig = h_req.valid & ~h_block & ~reset;
  assign h_pri  = (wait_cnt == 8'(MAX_WAIT));

  // Grant: starved H first, then C, then H; a blocked requester yields to the other.
  always_comb begin
    gnt = GNT_NONE;
    if (h_elig && h_pri) gnt = GNT_H;
    else if (c_elig)     gnt = GNT_C;
    else if (h_elig)     gnt = GNT_H;
  end

  // Select the winning request and drive the RAM; idle outputs are zero.
  always_comb begin
    case (gnt)
      GNT_C:   win = c_req;
      GNT_H:   win = h_req;
      default: win = '0;
    endcase
    wr_acc           = win.valid & win.write;
    c_rd_acc         = (gnt == GNT_C) & ~c_req.write;
    h_rd_acc         = (gnt == GNT_H) & ~h_req.write;
    bus.c_ready      = (gnt == GNT_C);
    bus.h_ready      = (gnt == GNT_H);
    bus.ram_write_rq = wr_acc;
    bus.ram_addr_in  = wr_acc ? addrSize'(win.addr) : '0;
    bus.ram_dataIn   = wr_acc ? win.wdata : '0;
    bus.ram_addr_out = (win.valid & ~win.write) ? addrSize'(win.addr) : '0;
    bus.ram_reset_n  = ~reset;
  end

  // H anti-starvation counter: counts stalled H cycles, saturates at MAX_WAIT.
  always_ff @(posedge clk) begin
    if (reset || !bus.h_valid || bus.h_ready) wait_cnt <= '0;
    else if (wait_cnt < 8'(MAX_WAIT))         wait_cnt <= wait_cnt + 8'd1;
  end

  // Remember the write issued this cycle; it is a hazard source for the next cycle only.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_wr_vld  <= 1'b0;
      last_wr_addr <= '0;
      last_wr_data <= '0;
    end else begin
      last_wr_vld <= wr_acc;
      if (wr_acc) begin
        last_wr_addr <= win.addr;
        last_wr_data <= win.wdata;
      end
    end
  end

  tape_ram_rd_port u_c_rd (
    .clk      (clk),
    .reset    (reset),
    .rd_acc   (c_rd_acc),
    .fwd      (c_fwd),
    .fwd_data (last_wr_data),
    .ram_data (bus.ram_dataOut),
    .rvalid   (bus.c_rvalid),
    .rdata    (bus.c_rdata)
  );

  tape_ram_rd_port u_h_rd (
    .clk      (clk),
    .reset    (reset),
    .rd_acc   (h_rd_acc),
    .fwd      (h_fwd),
    .fwd_data (last_wr_data),
    .ram_data (bus.ram_dataOut),
    .rvalid   (bus.h_rvalid),
    .rdata    (bus.h_rdata)
  );

endmodule

// File: tb/tb_tape_ram_arbiter.sv
// Bench for tape_ram_arbiter: directed scenarios plus randomized traffic against a memory model.
// The RAM is modelled here: write visible at its output two cycles after issue, cleared by ram_reset_n.
// Expected read data comes from an architectural memory updated in accept order.
module tb_tape_ram_arbiter;

  localparam int AW = 9;
  localparam int MW = 8;
`ifdef RAM_ARB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  tape_ram_arbiter_if #(.addrSize(AW)) bus ();

  tape_ram_arbiter #(.addrSize(AW), .MAX_WAIT(MW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // RAM model: one-cycle write pipeline, combinational read.
  logic [7:0]    mem [0:(1<<AW)-1];
  logic          pw_vld;
  logic [AW-1:0] pw_addr;
  logic [7:0]    pw_dat;

  always @(posedge clk) begin
    if (!bus.ram_reset_n) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 8'h00;
      pw_vld <= 1'b0;
    end else begin
      pw_vld  <= bus.ram_write_rq;
      pw_addr <= bus.ram_addr_in;
      pw_dat  <= bus.ram_dataIn;
      if (pw_vld) mem[pw_addr] <= pw_dat;
    end
  end

  assign bus.ram_dataOut = mem[bus.ram_addr_out];

  task automatic idle_inputs();
    bus.c_valid = 0; bus.c_write = 0; bus.c_addr = '0; bus.c_wdata = '0;
    bus.h_valid = 0; bus.h_write = 0; bus.h_addr = '0; bus.h_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Present one request and hold it until accepted (bounded); for reads, sample the response.
  task automatic xfer(input bit is_h, input logic wr, input logic [AW-1:0] a, input logic [7:0] d,
                      output bit acc, output int stalls, output logic rv, output logic [7:0] rd);
    acc = 0; stalls = 0; rv = 0; rd = '0;
    if (is_h) begin bus.h_valid = 1; bus.h_write = wr; bus.h_addr = a; bus.h_wdata = d; end
    else      begin bus.c_valid = 1; bus.c_write = wr; bus.c_addr = a; bus.c_wdata = d; end
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (is_h ? bus.h_ready : bus.c_ready) acc = 1; else stalls++;
      @(posedge clk); #1;
    end
    if (is_h) bus.h_valid = 0; else bus.c_valid = 0;
    if (acc && !wr) begin
      @(negedge clk);
      rv = is_h ? bus.h_rvalid : bus.c_rvalid;
      rd = is_h ? bus.h_rdata : bus.c_rdata;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    bus.c_valid = 1; bus.c_write = 1; bus.c_addr = 9'd1; bus.c_wdata = 8'hAA;
    bus.h_valid = 1; bus.h_write = 1; bus.h_addr = 9'd2; bus.h_wdata = 8'hBB;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({bus.c_ready, bus.h_ready, bus.ram_write_rq, bus.ram_reset_n, bus.c_rvalid, bus.h_rvalid} !== 6'b0) begin
        bad++;
        $display("FAIL reset_outputs cyc%0d: got {crdy,hrdy,wr,rstn,crv,hrv}=%b want 000000", i,
                 {bus.c_ready, bus.h_ready, bus.ram_write_rq, bus.ram_reset_n, bus.c_rvalid, bus.h_rvalid});
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    total++;
    if ({bus.c_rvalid, bus.h_rvalid, bus.c_rdata, bus.h_rdata, bus.ram_reset_n} !== {2'b00, 16'h0000, 1'b1}) begin
      bad++;
      $display("FAIL reset_release: got rv=%b%b rdata=%h/%h rstn=%b want 00 00/00 1",
               bus.c_rvalid, bus.h_rvalid, bus.c_rdata, bus.h_rdata, bus.ram_reset_n);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    bit acc; int st; logic rv; logic [7:0] rd;
    xfer(0, 1, 9'd5, 8'h2A, acc, st, rv, rd);
    total++; if (acc !== 1 || st != 0) begin bad++; $display("FAIL wr5_accept: got acc=%0d stalls=%0d want 1 0", acc, st); end
    @(posedge clk); #1;
    xfer(0, 0, 9'd5, 8'h00, acc, st, rv, rd);
    total++; if (acc !== 1 || st != 0 || rv !== 1 || rd !== 8'h2A) begin
      bad++; $display("FAIL rd5: got acc=%0d st=%0d rv=%b rd=%h want 1 0 1 2a", acc, st, rv, rd); end
    xfer(0, 0, 9'd9, 8'h00, acc, st, rv, rd);
    total++; if (rv !== 1 || rd !== 8'h00) begin bad++; $display("FAIL rd9_unwritten: got rv=%b rd=%h want 1 00", rv, rd); end
  endtask

  task automatic test_hazard();
    bit acc; int st; logic rv; logic [7:0] rd;
    do_reset();
    xfer(0, 1, 9'd7, 8'h55, acc, st, rv, rd);
    xfer(1, 0, 9'd7, 8'h00, acc, st, rv, rd);
    total++; if (acc !== 1 || st != (FWD ? 0 : 1)) begin
      bad++; $display("FAIL haz_h_stall: got acc=%0d stalls=%0d want 1 %0d", acc, st, FWD ? 0 : 1); end
    total++; if (rv !== 1 || rd !== 8'h55) begin bad++; $display("FAIL haz_h_data: got rv=%b rd=%h want 1 55", rv, rd); end
    // Hazarded H read alongside an unhazarded C read: C takes the slot.
    xfer(0, 1, 9'd7, 8'h66, acc, st, rv, rd);
    bus.c_valid = 1; bus.c_write = 0; bus.c_addr = 9'd8;
    bus.h_valid = 1; bus.h_write = 0; bus.h_addr = 9'd7;
    @(negedge clk);
    total++; if ({bus.c_ready, bus.h_ready} !== 2'b10) begin
      bad++; $display("FAIL haz_other_grant: got c/h ready=%b%b want 10", bus.c_ready, bus.h_ready); end
    @(posedge clk); #1;
    bus.c_valid = 0;
    @(negedge clk);
    total++; if (bus.h_ready !== 1 || bus.c_rvalid !== 1 || bus.c_rdata !== 8'h00) begin
      bad++; $display("FAIL haz_followup: got hrdy=%b crv=%b crd=%h want 1 1 00", bus.h_ready, bus.c_rvalid, bus.c_rdata); end
    @(posedge clk); #1;
    bus.h_valid = 0;
    @(negedge clk);
    total++; if (bus.h_rvalid !== 1 || bus.h_rdata !== 8'h66) begin
      bad++; $display("FAIL haz_h_data2: got rv=%b rd=%h want 1 66", bus.h_rvalid, bus.h_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_starvation();
    do_reset();
    bus.c_valid = 1; bus.c_write = 1; bus.c_addr = 9'h10; bus.c_wdata = 8'hC0;
    bus.h_valid = 1; bus.h_write = 1; bus.h_addr = 9'h20; bus.h_wdata = 8'hD0;
    for (int i = 1; i <= 27; i++) begin
      @(negedge clk);
      total++;
      if (bus.h_ready !== ((i % 9) == 0) || bus.c_ready !== ((i % 9) != 0)) begin
        bad++; $display("FAIL starve_cyc%0d: got c/h ready=%b%b want %b%b", i, bus.c_ready, bus.h_ready,
                        (i % 9) != 0, (i % 9) == 0);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_read();
    bit acc; int st; logic rv; logic [7:0] rd;
    do_reset();
    xfer(0, 1, 9'd4, 8'h77, acc, st, rv, rd);
    @(posedge clk); #1;
    bus.c_valid = 1; bus.c_write = 0; bus.c_addr = 9'd4;
    @(negedge clk);
    total++; if (bus.c_ready !== 1) begin bad++; $display("FAIL midrst_accept: got %b want 1", bus.c_ready); end
    @(posedge clk); #1;
    reset = 1'b1; bus.c_valid = 0;
    @(negedge clk);
    total++; if (bus.c_rvalid !== 0 || bus.c_rdata !== 8'h00) begin
      bad++; $display("FAIL midrst_rvalid: got rv=%b rd=%h want 0 00", bus.c_rvalid, bus.c_rdata); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      logic [AW-1:0] a;
      a = (k == 0) ? 9'd4 : (k == 1) ? 9'd0 : 9'd100;
      xfer(0, 0, a, 8'h00, acc, st, rv, rd);
      total++; if (rv !== 1 || rd !== 8'h00) begin
        bad++; $display("FAIL midrst_cleared@%0d: got rv=%b rd=%h want 1 00", a, rv, rd); end
    end
  endtask

  task automatic test_back_to_back();
    bit acc; int st; logic rv; logic [7:0] rd;
    xfer(0, 1, 9'd3, 8'h11, acc, st, rv, rd);
    xfer(0, 1, 9'd3, 8'h22, acc, st, rv, rd);
    total++; if (acc !== 1 || st != 0) begin bad++; $display("FAIL b2b_wr2: got acc=%0d st=%0d want 1 0", acc, st); end
    xfer(0, 0, 9'd3, 8'h00, acc, st, rv, rd);
    total++; if (st != (FWD ? 0 : 1) || rv !== 1 || rd !== 8'h22) begin
      bad++; $display("FAIL b2b_rd: got st=%0d rv=%b rd=%h want %0d 1 22", st, rv, rd, FWD ? 0 : 1); end
  endtask

  task automatic test_random();
    logic [7:0]    mm [0:3];
    bit            cp, hp, ce, he, pw, cacc, hacc, chz, hhz, hpri, exc, exh;
    logic          cw, hw;
    logic [AW-1:0] ca, ha, pa;
    logic [7:0]    cd, hd, cx, hx, cl, hl;
    int            hrun;
    do_reset();
    for (int i = 0; i < 4; i++) mm[i] = 8'h00;
    cp = 0; hp = 0; ce = 0; he = 0; pw = 0; pa = '0; cl = 0; hl = 0; hrun = 0;
    cw = 0; hw = 0; ca = '0; ha = '0; cd = 0; hd = 0; cx = 0; hx = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!cp && $urandom_range(0, 3) != 0) begin
        cp = 1; cw = 1'($urandom_range(0, 1)); ca = AW'($urandom_range(0, 3)); cd = 8'($urandom);
      end
      if (!hp && $urandom_range(0, 2) != 0) begin
        hp = 1; hw = 1'($urandom_range(0, 1)); ha = AW'($urandom_range(0, 3)); hd = 8'($urandom);
      end
      bus.c_valid = cp; bus.c_write = cw; bus.c_addr = ca; bus.c_wdata = cd;
      bus.h_valid = hp; bus.h_write = hw; bus.h_addr = ha; bus.h_wdata = hd;
      @(negedge clk);
      total++;
      if (bus.c_rvalid !== ce || bus.c_rdata !== (ce ? cx : cl)) begin
        bad++; $display("FAIL rnd_c_resp cyc%0d: got rv=%b rd=%h want %b %h", cyc, bus.c_rvalid, bus.c_rdata, ce, ce ? cx : cl);
      end
      if (ce) cl = cx;
      total++;
      if (bus.h_rvalid !== he || bus.h_rdata !== (he ? hx : hl)) begin
        bad++; $display("FAIL rnd_h_resp cyc%0d: got rv=%b rd=%h want %b %h", cyc, bus.h_rvalid, bus.h_rdata, he, he ? hx : hl);
      end
      if (he) hl = hx;
      chz  = !FWD && cp && !cw && pw && (ca == pa);
      hhz  = !FWD && hp && !hw && pw && (ha == pa);
      hpri = (hrun == MW);
      exh  = hp && !hhz && (hpri || !(cp && !chz));
      exc  = cp && !chz && !(hpri && hp && !hhz);
      total++;
      if (bus.c_ready !== exc || bus.h_ready !== exh) begin
        bad++; $display("FAIL rnd_grant cyc%0d: got c/h ready=%b%b want %b%b", cyc, bus.c_ready, bus.h_ready, exc, exh);
      end
      cacc = cp && (bus.c_ready === 1'b1);
      hacc = hp && (bus.h_ready === 1'b1);
      ce = 0; he = 0; pw = 0;
      if (cacc) begin
        if (cw) begin mm[ca[1:0]] = cd; pw = 1; pa = ca; end
        else    begin ce = 1; cx = mm[ca[1:0]]; end
        cp = 0;
      end
      if (hacc) begin
        if (hw) begin mm[ha[1:0]] = hd; pw = 1; pa = ha; end
        else    begin he = 1; hx = mm[ha[1:0]]; end
      end
      if (!hp || hacc) hrun = 0;
      else if (hrun < MW) hrun++;
      if (hacc) hp = 0;
      @(posedge clk); #1;
    end
    idle_inputs();
    @(negedge clk);
    total++;
    if (bus.c_rvalid !== ce || bus.h_rvalid !== he || (ce && bus.c_rdata !== cx) || (he && bus.h_rdata !== hx)) begin
      bad++; $display("FAIL rnd_tail: got rv=%b%b rd=%h/%h want %b%b %h/%h", bus.c_rvalid, bus.h_rvalid,
                      bus.c_rdata, bus.h_rdata, ce, he, cx, hx);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_hazard();
    test_starvation();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
